// File: rtl/apb_crypto_slave.sv
// apb_crypto_slave: APB register slave around an iterative rotate/XOR 32-bit cipher engine.
// Define APB_CRYPTO_SLVERR_EN to flag illegal accesses on pslverr (otherwise they complete silently).
module apb_crypto_slave #(
    parameter int ADDR_W = 32,
    parameter int ROUNDS = 8,
    parameter int ROT    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] A_KEY  = 3'd0;
    localparam logic [2:0] A_DIN  = 3'd1;
    localparam logic [2:0] A_DOUT = 3'd2;
    localparam logic [2:0] A_STAT = 3'd3;
    localparam logic [2:0] A_CTRL = 3'd4;

    localparam logic [4:0] ROT_S = 5'(ROT);
    localparam logic [4:0] LAST  = 5'(ROUNDS - 1);

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] t;
        t = {x, x} << s;
        return t[63:32];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] t;
        t = {x, x} >> s;
        return t[31:0];
    endfunction

    state_t      state;
    logic [31:0] key;
    logic        mode;
    logic [31:0] eng_d;
    logic [31:0] eng_k;
    logic        eng_mode;
    logic [4:0]  cnt;
    logic [31:0] data_out;
    logic        done;

    logic [2:0]  addr;
    logic        stall;
    logic        wr_fire;
    logic        rd_fire;
    logic        start;
    logic        status_rd;
    logic [31:0] rd_data;
    logic [31:0] d_next;
    logic [31:0] k_next;
    logic        unused_addr;

    assign addr        = paddr[4:2];
    assign unused_addr = ^{paddr[ADDR_W-1:5], paddr[1:0]};
    assign busy        = (state == RUN);

    // Anything that would disturb or observe the running engine waits for it to finish.
    assign stall = busy & ((pwrite & (addr == A_KEY || addr == A_DIN || addr == A_CTRL)) |
                           (~pwrite & (addr == A_DOUT)));

    assign pready    = ~rst_n & psel & penable & ~stall;
    assign wr_fire   = pready & pwrite;
    assign rd_fire   = pready & ~pwrite;
    assign start     = wr_fire & (addr == A_DIN);
    assign status_rd = rd_fire & (addr == A_STAT);

`ifdef APB_CRYPTO_SLVERR_EN
    logic bad_access;
    assign bad_access = (pwrite & (addr == A_DOUT || addr == A_STAT)) |
                        (~pwrite & (addr == A_DIN)) |
                        (addr >= 3'd5);
    assign pslverr = pready & bad_access;
`else
    assign pslverr = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        case (addr)
            A_KEY:   rd_data = key;
            A_DOUT:  rd_data = data_out;
            A_STAT:  rd_data = {30'd0, done, busy};
            A_CTRL:  rd_data = {31'd0, mode};
            default: rd_data = '0;
        endcase
    end

    assign prdata = rd_fire ? rd_data : '0;

    // Decrypt walks the key schedule backwards, so it starts from the last encrypt round key.
    always_comb begin
        if (eng_mode) begin
            d_next = rotr(eng_d, ROT_S) ^ eng_k;
            k_next = rotr(eng_k, 5'd1);
        end else begin
            d_next = rotl(eng_d ^ eng_k, ROT_S);
            k_next = rotl(eng_k, 5'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= IDLE;
            key      <= '0;
            mode     <= 1'b0;
            eng_d    <= '0;
            eng_k    <= '0;
            eng_mode <= 1'b0;
            cnt      <= '0;
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            if (wr_fire && addr == A_KEY)  key  <= pwdata;
            if (wr_fire && addr == A_CTRL) mode <= pwdata[0];
            if (status_rd)                 done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        eng_d    <= pwdata;
                        eng_k    <= mode ? rotl(key, LAST) : key;
                        eng_mode <= mode;
                        cnt      <= '0;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    eng_d <= d_next;
                    eng_k <= k_next;
                    cnt   <= cnt + 5'd1;
                    if (cnt == LAST) begin
                        data_out <= d_next;
                        state    <= DONE;
                        done     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_crypto_slave.sv
// tb_apb_crypto_slave: directed vector table plus hand-written multi-cycle sequences
// for apb_crypto_slave with ROUNDS=8, ROT=3.
module tb_apb_crypto_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

`ifdef APB_CRYPTO_SLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    apb_crypto_slave #(.ADDR_W(32), .ROUNDS(8), .ROT(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        bad;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Independent 8-round encrypt reference: rotate-left-by-3 of (d ^ k), key rotates left by 1.
    function automatic logic [31:0] model_enc(input logic [31:0] p, input logic [31:0] key);
        logic [31:0] d;
        logic [31:0] k;
        logic [31:0] x;
        d = p;
        k = key;
        for (int r = 0; r < 8; r++) begin
            x = d ^ k;
            d = {x[28:0], x[31:29]};
            k = {k[30:0], k[31]};
        end
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic err, output int waits);
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        @(negedge clk);
        penable = 1'b1;
        waits   = 0;
        #1;
        while (!pready && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        rd  = prdata;
        err = pslverr;
        if (!pready) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL apb_timeout: pready=%0b after %0d waits, expected 1", pready, waits);
        end
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        err;
    int          waits;
    logic [31:0] cipher;

    initial begin
        // Reset with an access phase presented: nothing may complete.
        rst_n   = 1'b1;
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_pready", {31'd0, pready}, 32'd0);
        checkOutput("rst_prdata", prdata, 32'd0);
        checkOutput("rst_pslverr", {31'd0, pslverr}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        rst_n   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;

        vecs.push_back('{1'b0, 32'h00, 32'h0,         1'b1, 32'h0,         1'b0, "key_reset"});
        vecs.push_back('{1'b1, 32'h00, 32'hA5A5_0F0F, 1'b0, 32'h0,         1'b0, "wr_key"});
        vecs.push_back('{1'b0, 32'h00, 32'h0,         1'b1, 32'hA5A5_0F0F, 1'b0, "rd_key"});
        vecs.push_back('{1'b1, 32'h10, 32'h0000_0003, 1'b0, 32'h0,         1'b0, "wr_ctrl"});
        vecs.push_back('{1'b0, 32'h10, 32'h0,         1'b1, 32'h0000_0001, 1'b0, "rd_ctrl"});
        vecs.push_back('{1'b1, 32'h10, 32'hFFFF_FFFE, 1'b0, 32'h0,         1'b0, "wr_ctrl0"});
        vecs.push_back('{1'b0, 32'h10, 32'h0,         1'b1, 32'h0,         1'b0, "rd_ctrl0"});
        vecs.push_back('{1'b0, 32'h0C, 32'h0,         1'b1, 32'h0,         1'b0, "rd_status"});
        vecs.push_back('{1'b0, 32'h04, 32'h0,         1'b1, 32'h0,         1'b1, "rd_datain"});
        vecs.push_back('{1'b0, 32'h08, 32'h0,         1'b1, 32'h0,         1'b0, "rd_dataout"});
        vecs.push_back('{1'b1, 32'h14, 32'h1234_5678, 1'b0, 32'h0,         1'b1, "wr_unmapped"});
        vecs.push_back('{1'b0, 32'h14, 32'h0,         1'b1, 32'h0,         1'b1, "rd_unmapped"});
        vecs.push_back('{1'b1, 32'h0C, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, "wr_status"});
        vecs.push_back('{1'b1, 32'h08, 32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, "wr_dataout"});
        vecs.push_back('{1'b0, 32'h0C, 32'h0,         1'b1, 32'h0,         1'b0, "rd_status2"});
        vecs.push_back('{1'b0, 32'h08, 32'h0,         1'b1, 32'h0,         1'b0, "rd_dataout2"});
        vecs.push_back('{1'b0, 32'h00, 32'h0,         1'b1, 32'hA5A5_0F0F, 1'b0, "rd_key_kept"});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, waits);
            checkOutput({vecs[i].name, "_waits"}, waits, 32'd0);
            checkOutput({vecs[i].name, "_err"}, {31'd0, err}, {31'd0, ERR_EN & vecs[i].bad});
            if (vecs[i].chk_rd) checkOutput({vecs[i].name, "_data"}, rd, vecs[i].exp_rd);
        end

        // KEY=0 encrypt of 1: eight rotl-by-3 steps give rotl(1,24); DATA_OUT read stalls.
        applyStimulus(1'b1, 32'h00, 32'h0, rd, err, waits);
        applyStimulus(1'b1, 32'h04, 32'h0000_0001, rd, err, waits);
        applyStimulus(1'b0, 32'h08, 32'h0, rd, err, waits);
        checkOutput("stall_waits", waits, 32'd7);
        checkOutput("enc1_result", rd, 32'h0100_0000);
        checkOutput("enc1_busy_after", {31'd0, busy}, 32'd0);
        applyStimulus(1'b0, 32'h0C, 32'h0, rd, err, waits);
        checkOutput("enc1_status_done", rd, 32'h2);
        applyStimulus(1'b0, 32'h0C, 32'h0, rd, err, waits);
        checkOutput("enc1_status_clr", rd, 32'h0);

        // Round trip; STATUS during busy is zero-wait and reports busy only.
        applyStimulus(1'b1, 32'h00, 32'h1234_5678, rd, err, waits);
        applyStimulus(1'b1, 32'h04, 32'hDEAD_BEEF, rd, err, waits);
        applyStimulus(1'b0, 32'h0C, 32'h0, rd, err, waits);
        checkOutput("busy_status", rd, 32'h1);
        checkOutput("busy_status_waits", waits, 32'd0);
        applyStimulus(1'b0, 32'h08, 32'h0, rd, err, waits);
        cipher = rd;
        checkOutput("enc_cipher", cipher, model_enc(32'hDEAD_BEEF, 32'h1234_5678));
        applyStimulus(1'b1, 32'h10, 32'h1, rd, err, waits);
        applyStimulus(1'b1, 32'h04, cipher, rd, err, waits);
        applyStimulus(1'b0, 32'h0C, 32'h0, rd, err, waits);
        checkOutput("start_clears_done", rd, 32'h1);
        applyStimulus(1'b0, 32'h08, 32'h0, rd, err, waits);
        checkOutput("dec_plain", rd, 32'hDEAD_BEEF);

        // Reset in the middle of an operation aborts it and clears DATA_OUT.
        applyStimulus(1'b1, 32'h10, 32'h0, rd, err, waits);
        applyStimulus(1'b1, 32'h04, 32'h5555_AAAA, rd, err, waits);
        @(negedge clk);
        rst_n   = 1'b1;
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = 32'h08;
        @(negedge clk);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_pready", {31'd0, pready}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        applyStimulus(1'b0, 32'h0C, 32'h0, rd, err, waits);
        checkOutput("midrst_status", rd, 32'h0);
        applyStimulus(1'b0, 32'h08, 32'h0, rd, err, waits);
        checkOutput("midrst_dataout", rd, 32'h0);
        checkOutput("midrst_dataout_waits", waits, 32'd0);
        applyStimulus(1'b0, 32'h00, 32'h0, rd, err, waits);
        checkOutput("midrst_key", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/apb_crypto_slave.md
Name: apb_crypto_slave

Overview:
- APB slave stage directly downstream of apb_master; one instance hangs on each apb_bus port.
- Holds a key/control register file and an iterative multi-round 32-bit cipher engine.
- Writes to DATA_IN start a multi-cycle encrypt or decrypt operation.
- pready is stretched while the engine is busy, so the master's wait-state handling is exercised.

Parameters:
- ADDR_W, 32, APB address width; only paddr[4:2] is decoded.
- ROUNDS, 8, cipher rounds per operation (1..31).
- ROT, 3, rotate amount per round (1..31).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset.
- psel  input  1  APB select.
- penable  input  1  APB access phase.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  byte address.
- pwdata  input  32  write data.
- prdata  output  32  read data, valid when pready=1 and pwrite=0.
- pready  output  1  transfer complete.
- pslverr  output  1  error response; see Optional Feature.
- busy  output  1  engine running (debug/interrupt use).

Behaviour:
- Clocking: one clock, clk. Reset rst_n is synchronous and active-high: rst_n=1 sampled at a clk edge resets the block.
- Reset values: all registers 0, engine idle; busy=0, done=0.
- Outputs during reset: prdata=0, pready=0, pslverr=0.
- Register map (paddr[4:2]):
  - 0 KEY (RW).
  - 1 DATA_IN (W; write starts an operation; reads 0).
  - 2 DATA_OUT (R).
  - 3 STATUS (R): bit0 busy, bit1 done, other bits 0.
  - 4 CTRL (RW): bit0 mode, 0 = encrypt, 1 = decrypt; other bits 0.
  - 5-7 unmapped: reads 0, writes ignored.
- APB protocol:
  - Setup phase is psel=1, penable=0. Access phase is psel=1, penable=1.
  - pready is combinational: pready = psel & penable & ~stall.
  - Register writes commit on the clk edge where the access phase has pready=1.
  - pready=0 whenever psel=0.
- Stall rule: stall=1 when busy=1 and the access is any of: a DATA_IN write, a DATA_OUT read, a KEY write, a CTRL write.
  - All other accesses complete with zero wait states.
  - A stalled transfer completes in the first cycle after busy falls.
- Engine FSM states: IDLE, RUN, DONE.
  - Leaves IDLE or DONE on an accepted DATA_IN write.
  - Enters RUN at cycle T+1, where T is the acceptance cycle.
  - Stays in RUN exactly ROUNDS cycles; busy=1 throughout RUN.
  - On the last RUN cycle edge: DATA_OUT is loaded, state moves to DONE, done=1.
- Round counter: 5 bits, counts 0..ROUNDS-1.
- Encrypt round: d = rotl(d ^ k, ROT), then k = rotl(k,1).
  - Initial k = KEY.
- Decrypt round: d = rotr(d, ROT) ^ k, then k = rotr(k,1).
  - Initial k = rotl(KEY, ROUNDS-1).
  - Decrypt of an encrypt result under the same KEY returns the original plaintext.
- KEY and mode are latched into the engine at start; later register changes do not affect a running operation.
- done=1 persists until either:
  - a STATUS read completes (clears on that edge), or
  - a new DATA_IN write is accepted.
- DATA_OUT holds its value until the next operation completes.
- Simultaneous events: on the same edge, a STATUS read returns done=1, the clear happens, and a new start has priority over the clear. No new start can coincide with the RUN->DONE edge, because DATA_IN writes stall while busy.
- Reset mid-operation: engine aborts to IDLE, DATA_OUT=0; any pending stalled transfer is dropped.
- Arithmetic is 32-bit with wrap-around only; rotates are modulo 32.

Optional Feature:
- Macro: APB_CRYPTO_SLVERR_EN.
- Defined: pslverr=1 together with pready=1 when the access is any of:
  - a write to DATA_OUT or STATUS,
  - a read from DATA_IN,
  - any access to addresses 5-7.
  - An errored write has no effect.
- Undefined: pslverr tied to 0; the same accesses complete silently (reads return 0, writes ignored).

Test Plan:
- Reset: rst_n=1 for 2 cycles mid-RUN, then 0 -> busy=0, STATUS=0x0, DATA_OUT=0, pready=0 during reset.
- Zero-wait RW: write KEY=0xA5A5_0F0F, then read KEY -> prdata=0xA5A5_0F0F; each access phase has pready=1 in its first cycle.
- Encrypt, ROUNDS=1, ROT=3: KEY=0, CTRL=0, DATA_IN=0x0000_0001 -> busy=1 for 1 cycle, then DATA_OUT=0x0000_0008, STATUS=0x2; a second STATUS read returns 0x0.
- Round trip, ROUNDS=8: KEY=0x1234_5678, encrypt DATA_IN=0xDEAD_BEEF -> ciphertext C; CTRL=1, DATA_IN=C -> DATA_OUT=0xDEAD_BEEF.
- Stall: read DATA_OUT one cycle after a DATA_IN write with ROUNDS=8 -> pready=0 for the remaining busy cycles, then pready=1 with the new result. A STATUS read during busy completes with 0 waits and returns 0x1.
- Error (macro defined): write paddr=0x14 -> pready=1, pslverr=1, no register change. Macro undefined -> pslverr=0.
